// File: rtl/comparador_iterativo_seq_pkg.sv
// Shared encodings for the sequential iterative comparator: digit relation,
// output-function select and controller states, plus the function that maps
// a final relation onto the selected output f.
package comparador_pkg;

    typedef enum logic [1:0] {
        REL_EQ = 2'b00,
        REL_GT = 2'b01,
        REL_LT = 2'b10
    } rel_t;

    typedef enum logic [1:0] {
        MODE_EQ = 2'b00,
        MODE_GT = 2'b01,
        MODE_LT = 2'b10,
        MODE_NE = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Selected output function of the final relation.
    function automatic logic rel_to_f(input mode_t mode, input rel_t rel);
        logic res;
        case (mode)
            MODE_EQ: res = (rel == REL_EQ);
            MODE_GT: res = (rel == REL_GT);
            MODE_LT: res = (rel == REL_LT);
            MODE_NE: res = (rel != REL_EQ);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/comparador_iterativo_seq_if.sv
// Request/result bundle of the iterative comparator. The requester drives
// the operands, mode and start; the comparator returns status and results.
interface comparador_iterativo_seq_if #(
    parameter int WIDTH = 12
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             z;
    logic             y;
    logic             sgn;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             f;

    modport master (
        output start, A, B, z, y, sgn,
        input  busy, done, eq, gt, lt, f
    );

    modport slave (
        input  start, A, B, z, y, sgn,
        output busy, done, eq, gt, lt, f
    );
endinterface

// File: rtl/comparador_iterativo_seq_celda_digito.sv
// celda_digito: combinational digit cell. Once a higher digit has decided
// the relation it is passed through unchanged; otherwise this digit decides.
// On the most significant digit in signed mode, differing sign bits decide
// the relation on their own (the negative operand is the smaller one).
module celda_digito
    import comparador_pkg::*;
#(
    parameter int CHUNK = 3
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  rel_t             rel_in,
    input  logic             is_msb,
    input  logic             sgn,
    output rel_t             rel_out
);

    // Carry an already-decided relation, otherwise compare this digit.
    always_comb begin
        rel_out = rel_in;
        if (rel_in == REL_EQ) begin
            if (is_msb && sgn && (a[CHUNK-1] != b[CHUNK-1])) begin
                rel_out = a[CHUNK-1] ? REL_LT : REL_GT;
            end else if (a > b) begin
                rel_out = REL_GT;
            end else if (a < b) begin
                rel_out = REL_LT;
            end else begin
                rel_out = REL_EQ;
            end
        end
    end

endmodule

// File: rtl/comparador_iterativo_seq.sv
// comparador_iterativo_seq: compares two WIDTH-bit operands one CHUNK-bit
// digit per clock, most significant digit first, carrying the relation
// between digits. start/busy/done handshake, signed mode and four output
// functions selected by {z,y}.
// Optional feature macro: COMPARADOR_EARLY_EXIT_EN -- when defined, the
// comparison finishes on the first digit that decides the relation.
module comparador_iterativo_seq
    import comparador_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int CHUNK = 3
) (
    input logic                       clk,
    input logic                       rst,
    comparador_iterativo_seq_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    mode_t            mode_r;
    logic             sgn_r;
    logic [IDX_W-1:0] idx;
    rel_t             rel;
    logic             busy_r;
    logic             done_r;
    logic             eq_r;
    logic             gt_r;
    logic             lt_r;
    logic             f_r;

    logic [CHUNK-1:0] a_dig;
    logic [CHUNK-1:0] b_dig;
    logic             is_msb;
    logic             finish;
    rel_t             rel_next;

    // Select the digit currently addressed by idx from the latched operands.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDX_W'(i)) begin
                a_dig = a_r[i*CHUNK +: CHUNK];
                b_dig = b_r[i*CHUNK +: CHUNK];
            end
        end
    end

    assign is_msb = (idx == IDX_LAST);

    celda_digito #(
        .CHUNK (CHUNK)
    ) u_celda (
        .a       (a_dig),
        .b       (b_dig),
        .rel_in  (rel),
        .is_msb  (is_msb),
        .sgn     (sgn_r),
        .rel_out (rel_next)
    );

`ifdef COMPARADOR_EARLY_EXIT_EN
    assign finish = (idx == '0) || (rel_next != REL_EQ);
`else
    assign finish = (idx == '0);
`endif

    // Controller: latch request, walk the digits, register results, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= MODE_EQ;
            sgn_r  <= 1'b0;
            idx    <= '0;
            rel    <= REL_EQ;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            eq_r   <= 1'b0;
            gt_r   <= 1'b0;
            lt_r   <= 1'b0;
            f_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r    <= bus.A;
                        b_r    <= bus.B;
                        mode_r <= mode_t'({bus.z, bus.y});
                        sgn_r  <= bus.sgn;
                        idx    <= IDX_LAST;
                        rel    <= REL_EQ;
                        busy_r <= 1'b1;
                        eq_r   <= 1'b0;
                        gt_r   <= 1'b0;
                        lt_r   <= 1'b0;
                        f_r    <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    rel <= rel_next;
                    if (finish) begin
                        idx    <= '0;
                        eq_r   <= (rel_next == REL_EQ);
                        gt_r   <= (rel_next == REL_GT);
                        lt_r   <= (rel_next == REL_LT);
                        f_r    <= rel_to_f(mode_r, rel_next);
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.eq   = eq_r;
    assign bus.gt   = gt_r;
    assign bus.lt   = lt_r;
    assign bus.f    = f_r;

endmodule

// File: tb/tb_comparador_iterativo_seq.sv
// Self-checking bench for comparador_iterativo_seq (WIDTH=12, CHUNK=3).
// Expected results come from a behavioural model and go into a scoreboard
// queue when a request is driven; a monitor pops and compares on each done.
// Build with COMPARADOR_EARLY_EXIT_EN defined to expect early-exit latency.
module tb_comparador_iterativo_seq;

    localparam int WIDTH  = 12;
    localparam int CHUNK  = 3;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        logic f;
        int   lat;
        int   start_edge;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   edge_cnt;
    int   done_cnt;
    exp_t sb[$];

    comparador_iterativo_seq_if #(.WIDTH(WIDTH)) bus ();

    comparador_iterativo_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so latency can be measured in clocks.
    always @(posedge clk) edge_cnt++;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Behavioural reference: full-width compare plus expected latency.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [1:0] mode, input logic s);
        exp_t e;
        logic signed [WIDTH:0] sa;
        logic signed [WIDTH:0] sb_v;
        logic [WIDTH-1:0] da;
        logic [WIDTH-1:0] db;
        sa   = s ? {a[WIDTH-1], a} : {1'b0, a};
        sb_v = s ? {b[WIDTH-1], b} : {1'b0, b};
        e.eq = (sa == sb_v);
        e.gt = (sa > sb_v);
        e.lt = (sa < sb_v);
        case (mode)
            2'b00:   e.f = e.eq;
            2'b01:   e.f = e.gt;
            2'b10:   e.f = e.lt;
            default: e.f = ~e.eq;
        endcase
        e.lat = NCHUNK;
`ifdef COMPARADOR_EARLY_EXIT_EN
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            da = (a >> (i * CHUNK)) & WIDTH'((1 << CHUNK) - 1);
            db = (b >> (i * CHUNK)) & WIDTH'((1 << CHUNK) - 1);
            if (da != db && e.lat == NCHUNK) e.lat = NCHUNK - i;
        end
`else
        da = '0;
        db = '0;
`endif
        e.start_edge = 0;
        return e;
    endfunction

    // Drive one accepted request (caller guarantees the DUT is idle).
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [1:0] mode, input logic s);
        exp_t e;
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.z     = mode[1];
        bus.y     = mode[0];
        bus.sgn   = s;
        bus.start = 1'b1;
        e = model(a, b, mode, s);
        e.start_edge = edge_cnt + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait, with a bound, until every queued result has been seen.
    task automatic waitDone();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("eq", bus.eq, e.eq);
                checkOutput("gt", bus.gt, e.gt);
                checkOutput("lt", bus.lt, e.lt);
                checkOutput("f", bus.f, e.f);
                checkOutput("latency", edge_cnt - e.start_edge, e.lat);
                checkOutput("busy_at_done", bus.busy, 1);
            end
        end
    end

    initial begin
        int dc;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        checks   = 0;
        failures = 0;
        edge_cnt = 0;
        done_cnt = 0;

        // Reset held two cycles with start asserted: everything stays zero.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.A     = 12'h5A3;
        bus.B     = 12'h123;
        bus.z     = 1'b0;
        bus.y     = 1'b1;
        bus.sgn   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset_outs",
                        {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.f}, 0);
        end
        rst       = 1'b0;
        bus.start = 1'b0;

        // Equal operands, f=eq, with exact handshake timing.
        applyStimulus(12'h5A3, 12'h5A3, 2'b00, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("busy_in_run", bus.busy, 1);
            checkOutput("done_in_run", bus.done, 0);
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("busy_after_done", bus.busy, 0);
        checkOutput("done_single", bus.done, 0);
        checkOutput("eq_hold", bus.eq, 1);
        checkOutput("sb_empty_t2", sb.size(), 0);

        // Unsigned versus signed on the sign-bit boundary.
        applyStimulus(12'h800, 12'h7FF, 2'b01, 1'b0);
        waitDone();
        applyStimulus(12'h800, 12'h7FF, 2'b01, 1'b1);
        waitDone();

        // Extra starts during RUN and during DONE are ignored.
        dc = done_cnt;
        applyStimulus(12'h001, 12'h002, 2'b10, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.A     = 12'hFFF;
        bus.B     = 12'h000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("done_before_extra", bus.done, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("idle_after_ignored", {bus.busy, bus.done}, 0);
        end
        checkOutput("one_done_pulse", done_cnt - dc, 1);
        checkOutput("lt_hold", bus.lt, 1);

        // Reset in the second RUN cycle aborts without a done pulse.
        dc = done_cnt;
        applyStimulus(12'h123, 12'h124, 2'b11, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_outs",
                    {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.f}, 0);
        sb.delete();
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("abort_idle",
                        {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.f}, 0);
        end
        checkOutput("abort_no_done", done_cnt - dc, 0);

        // Decided on the first digit: short latency only with early exit.
        applyStimulus(12'hE00, 12'h100, 2'b01, 1'b0);
        waitDone();

        // Random requests across all modes, signed and unsigned.
        for (int i = 0; i < 10; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 3 == 0) ? ra : WIDTH'($urandom);
            if (i % 4 == 1) rb = ra ^ 12'h001;
            applyStimulus(ra, rb, 2'(i), 1'(i >> 1));
            waitDone();
        end

        checkOutput("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comparador_iterativo_seq.md
Name: comparador_iterativo_seq

Overview:
Sequential, parametrised successor of the left-to-right iterative comparator cell. It compares two WIDTH-bit operands one CHUNK-bit digit per clock, starting at the most significant digit. A relation state (EQ/GT/LT) is carried between digits, as g_in/g_mid is carried between cells in the combinational array. Adds start/busy/done handshake, signed mode, four selectable output functions and optional early termination.

Parameters:
WIDTH, 12, operand width in bits; must be a multiple of CHUNK.
CHUNK, 3, bits compared per clock (digit width).
NCHUNK, WIDTH/CHUNK, derived localparam, digits per comparison; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; accepted only in IDLE.
A  input  WIDTH  operand A; sampled on the accepted start.
B  input  WIDTH  operand B; sampled on the accepted start.
z  input  1  mode bit 1; sampled on start.
y  input  1  mode bit 0; sampled on start.
sgn  input  1  1 = two's-complement compare; sampled on start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; result valid.
eq  output  1  A == B.
gt  output  1  A > B.
lt  output  1  A < B.
f  output  1  selected function of the relation.

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk.
- rst has priority over everything, including a start in the same cycle.
- Reset values: state=IDLE, busy=0, done=0, eq=0, gt=0, lt=0, f=0, digit index=0, rel=EQ.
- FSM states: IDLE, RUN, DONE.
  - IDLE with start=1: latch A, B, {z,y}, sgn; idx=NCHUNK-1; rel=EQ; go to RUN.
  - RUN, each edge: evaluate digit idx. If rel==EQ, rel takes the digit comparison result; otherwise rel holds. Then idx decrements.
  - RUN, when idx==0 is evaluated: register eq/gt/lt/f from the final rel and go to DONE.
  - DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency: start sampled at edge k; done is high in the cycle following edge k+NCHUNK. Throughput is one comparison per NCHUNK+2 cycles.
- Signed mode applies to the MSB digit only: if the sign bits differ, the operand with sign bit 1 is LT, independent of the remaining bits. Otherwise the MSB digit compares unsigned. All lower digits always compare unsigned.
- Function f from {z,y}:
  - 00: f=eq
  - 01: f=gt
  - 10: f=lt
  - 11: f=~eq
- eq/gt/lt are one-hot after the first done and hold until the next accepted start, at which point they clear to 0.
- start while busy=1, including in the DONE cycle, is ignored. It is not queued.
- Changing A, B, z, y or sgn during RUN has no effect.
- rst during RUN or DONE: the next edge returns to IDLE with reset values, and no done pulse is emitted.
- NCHUNK==1: a single RUN cycle; the sign rule and the final-digit rule apply to the same digit.

Optional Feature:
Macro COMPARADOR_EARLY_EXIT_EN.
- Defined: in RUN, as soon as rel becomes non-EQ, results are registered and the FSM goes to DONE on that edge. Latency is variable, 1..NCHUNK RUN cycles. An all-equal compare still takes NCHUNK RUN cycles.
- Undefined: fixed latency of NCHUNK RUN cycles in every case; results are bit-identical to the defined build.

Decomposition:
- Shared package comparador_pkg holds:
  - relation encoding: REL_EQ=2'b00, REL_GT=2'b01, REL_LT=2'b10;
  - mode encoding: MODE_EQ=2'b00, MODE_GT=2'b01, MODE_LT=2'b10, MODE_NE=2'b11;
  - FSM state encoding: IDLE, RUN, DONE.
- Natural sub-module: celda_digito, a combinational parametrised digit cell.
  - Inputs: CHUNK-bit a and b, rel_in, is_msb, sgn.
  - Output: rel_out.
  - The top instantiates it once and muxes the digit by idx.

Test Plan (WIDTH=12, CHUNK=3):
1. rst=1 for 2 cycles with start=1 -> all outputs 0 and busy=0 throughout.
2. A=12'h5A3, B=12'h5A3, {z,y}=00, sgn=0; start at edge k -> done high after edge k+4; eq=1, gt=0, lt=0, f=1; busy low again after edge k+5.
3. A=12'h800, B=12'h7FF, {z,y}=01: with sgn=0 -> gt=1, f=1; with sgn=1 -> lt=1, f=0.
4. A=12'h001, B=12'h002, {z,y}=10; a second start with different operands is pulsed during RUN and again during DONE -> lt=1, f=1; exactly one done pulse; the second start is ignored; latency is 4 in both builds.
5. A=12'h123, B=12'h124, {z,y}=11; rst asserted in the 2nd RUN cycle -> IDLE on the next edge; done never pulses; eq/gt/lt/f=0.
6. COMPARADOR_EARLY_EXIT_EN defined, A=12'hE00, B=12'h100, {z,y}=01 -> done after edge k+1, gt=1, f=1. Same stimulus undefined -> done after edge k+4 with identical results.
